cpu_fabric_cix_bridge: RTL and testbench
========================================

# cpu_fabric_cix_bridge

Parametrised custom-instruction bridge between the hard CPU and the FPGA fabric, placed in the east CPU I/O tile column. It generalises fixed 4-bit operand-in and result-out passing to configurable-width operands, N result channels and a request/response handshake. It adds completion detection (fabric done strobe or fixed latency), timeout and error reporting. Operands and the selected result are registered; the fabric sees a one-cycle start pulse per instruction.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width in bits (≥1)
- NUM_RES, 3, number of fabric result channels (1..16)
- SEL_W, 4, width of result-select field (≥ clog2(NUM_RES), ≥1)
- TIMEOUT, 255, max RUN cycles before error (2..65535)

Ports:
- UserCLK  in  1  fabric user clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  CPU instruction request
- cpu_req_ready  out  1  bridge accepts request
- cpu_opa  in  DATA_WIDTH  operand A
- cpu_opb  in  DATA_WIDTH  operand B
- cpu_res_sel  in  SEL_W  result channel to return
- cpu_rsp_valid  out  1  response available
- cpu_rsp_ready  in  1  CPU accepts response
- cpu_rsp_data  out  DATA_WIDTH  selected result
- cpu_rsp_err  out  1  timeout or bad select
- fab_opa  out  DATA_WIDTH  registered operand A to fabric
- fab_opb  out  DATA_WIDTH  registered operand B to fabric
- fab_start  out  1  one-cycle start pulse
- fab_res  in  NUM_RES*DATA_WIDTH  result channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- fab_done  in  1  fabric completion strobe
- cfg_fixed_lat  in  1  1: fixed-latency completion, 0: fab_done completion
- cfg_latency  in  4  fixed latency in RUN cycles
- perf_cycles  out  32  accumulated RUN cycles (see Configuration)

## Operation
- FSM states IDLE, RUN, RESP; reset → IDLE.
- IDLE: cpu_req_ready=1. On cpu_req_valid&cpu_req_ready: capture opa/opb into fab_opa/fab_opb, latch sel, clear run counter cnt.
  - sel ≥ NUM_RES → RESP with rsp_data=0, rsp_err=1, no fab_start.
  - else → RUN.
- RUN: cpu_req_ready=0. fab_start=1 only in first RUN cycle (cnt=0). cnt increments each RUN cycle.
  - Complete when (cfg_fixed_lat=0 and fab_done=1) or (cfg_fixed_lat=1 and cnt==cfg_latency). fab_done counts in any RUN cycle, including the start cycle.
  - On complete: cpu_rsp_data ← fab_res channel sel, cpu_rsp_err ← 0, → RESP.
  - Not complete and cnt==TIMEOUT-1: rsp_data ← 0, rsp_err ← 1, → RESP. Completion in same cycle wins over timeout.
- RESP: cpu_rsp_valid=1; rsp_data/err stable until cpu_rsp_valid&cpu_rsp_ready, then → IDLE. No new request accepted in RESP, even in the handshake cycle.
- fab_done outside RUN ignored. cfg_* sampled every RUN cycle; must be held static during an instruction.
- fab_opa/fab_opb hold last captured operands until next capture.

## Timing
- All outputs registered. Reset values: cpu_req_ready=0, cpu_rsp_valid=0, cpu_rsp_data=0, cpu_rsp_err=0, fab_opa=0, fab_opb=0, fab_start=0, perf_cycles=0. cpu_req_ready rises on first UserCLK edge after rst_n release.
- Request accepted at edge T: fab_opa/opb/fab_start valid after T; fab_start deasserts after T+1.
- Fixed mode, latency L: cpu_rsp_valid high from edge T+2+L.
- Done mode: fab_done high in RUN cycle k (k=0 is the start cycle) → cpu_rsp_valid high from edge T+2+k.
- Timeout: cpu_rsp_valid with err from edge T+1+TIMEOUT.
- Bad select: cpu_rsp_valid from edge T+1.
- Min back-to-back: next request accepted one cycle after response handshake.
- rst_n low at any time: immediate return to IDLE, all outputs to reset values, in-flight instruction discarded, no response.

## Configuration
- CIX_PERF_CNT_EN defined: perf_cycles increments once per RUN cycle, saturating at 32'hFFFF_FFFF; cleared only by reset.
- Not defined: counter logic omitted, perf_cycles tied to 0.

## Test plan
- DATA_WIDTH=32, cfg_fixed_lat=1, cfg_latency=3, opa=0x1234, sel=1, fab_res ch1=0xCAFEF00D → one fab_start pulse; rsp_valid 5 cycles after accept; data=0xCAFEF00D, err=0.
- cfg_fixed_lat=0, fab_done pulsed in start cycle, sel=0 → rsp 2 cycles after accept with ch0 data; then fab_done pulsed again in IDLE → no effect.
- fab_done never asserted, TIMEOUT=8 → rsp_valid 9 cycles after accept, data=0, err=1; perf_cycles=8 with CIX_PERF_CNT_EN, 0 without.
- NUM_RES=3, sel=3 → rsp 1 cycle after accept, err=1, fab_start never asserted.
- Hold cpu_rsp_ready=0 for 10 cycles with cpu_req_valid=1 → rsp data/err stable, cpu_req_ready=0 throughout; accept occurs one cycle after response handshake.
- Assert rst_n=0 mid-RUN → all outputs at reset values immediately, no response after release, next request completes normally.

Source files
------------

// File: rtl/cpu_fabric_cix_bridge.sv
// Custom-instruction bridge: CPU request/response to fabric start/done.
// Optional CIX_PERF_CNT_EN adds a saturating RUN-cycle counter.
module cpu_fabric_cix_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RES    = 3,
  parameter int SEL_W      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          UserCLK,
  input  logic                          rst_n,
  input  logic                          cpu_req_valid,
  output logic                          cpu_req_ready,
  input  logic [DATA_WIDTH-1:0]         cpu_opa,
  input  logic [DATA_WIDTH-1:0]         cpu_opb,
  input  logic [SEL_W-1:0]              cpu_res_sel,
  output logic                          cpu_rsp_valid,
  input  logic                          cpu_rsp_ready,
  output logic [DATA_WIDTH-1:0]         cpu_rsp_data,
  output logic                          cpu_rsp_err,
  output logic [DATA_WIDTH-1:0]         fab_opa,
  output logic [DATA_WIDTH-1:0]         fab_opb,
  output logic                          fab_start,
  input  logic [NUM_RES*DATA_WIDTH-1:0] fab_res,
  input  logic                          fab_done,
  input  logic                          cfg_fixed_lat,
  input  logic [3:0]                    cfg_latency,
  output logic [31:0]                   perf_cycles
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  req_ready_q, req_ready_d;
  logic                  start_q, start_d;

  logic                  accept;
  logic                  bad_sel;
  logic                  done_hit;
  logic                  tmo_hit;
  logic                  rsp_hs;
  logic [DATA_WIDTH-1:0] res_mux;

  assign accept   = (state_q == IDLE) && cpu_req_valid && req_ready_q;
  assign bad_sel  = int'(cpu_res_sel) >= NUM_RES;
  assign done_hit = cfg_fixed_lat ? (cnt_q == CNT_W'(cfg_latency))
                                  : fab_done;
  assign tmo_hit  = cnt_q == CNT_W'(TIMEOUT - 1);
  assign rsp_hs   = rsp_valid_q && cpu_rsp_ready;

  always_comb begin
    res_mux = '0;
    for (int k = 0; k < NUM_RES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        res_mux = fab_res[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = bad_sel ? RESP : RUN;
      RUN:  if (done_hit || tmo_hit) state_d = RESP;
      RESP: if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response data is loaded on entry to RESP; valid follows one cycle later.
  always_comb begin
    opa_d       = accept ? cpu_opa : opa_q;
    opb_d       = accept ? cpu_opb : opb_q;
    sel_d       = accept ? cpu_res_sel : sel_q;
    cnt_d       = cnt_q;
    start_d     = accept && !bad_sel;
    req_ready_d = state_d == IDLE;
    rsp_valid_d = (state_q == RESP) && !rsp_hs;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      cnt_d = '0;
      if (bad_sel) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (done_hit) begin
        rsp_data_d = res_mux;
        rsp_err_d  = 1'b0;
      end else if (tmo_hit) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sel_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      start_q     <= start_d;
    end
  end

`ifdef CIX_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == RUN && perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign cpu_req_ready = req_ready_q;
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rsp_data  = rsp_data_q;
  assign cpu_rsp_err   = rsp_err_q;
  assign fab_opa       = opa_q;
  assign fab_opb       = opb_q;
  assign fab_start     = start_q;

endmodule

// File: tb/tb_cpu_fabric_cix_bridge.sv
// Directed testbench for cpu_fabric_cix_bridge (TIMEOUT=8, NUM_RES=3).
// Expects perf_cycles activity only when CIX_PERF_CNT_EN is defined.
module tb_cpu_fabric_cix_bridge;

  localparam int DW = 32;
  localparam int NR = 3;

  logic          clk;
  logic          rst_n;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [DW-1:0] cpu_opa;
  logic [DW-1:0] cpu_opb;
  logic [3:0]    cpu_res_sel;
  logic          cpu_rsp_valid;
  logic          cpu_rsp_ready;
  logic [DW-1:0] cpu_rsp_data;
  logic          cpu_rsp_err;
  logic [DW-1:0] fab_opa;
  logic [DW-1:0] fab_opb;
  logic          fab_start;
  logic [NR*DW-1:0] fab_res;
  logic          fab_done;
  logic          cfg_fixed_lat;
  logic [3:0]    cfg_latency;
  logic [31:0]   perf_cycles;

  int pass_cnt = 0;
  int total = 0;

  localparam logic [31:0] CH0 = 32'h1111_1111;
  localparam logic [31:0] CH1 = 32'hCAFE_F00D;
  localparam logic [31:0] CH2 = 32'h2222_2222;

  cpu_fabric_cix_bridge #(
    .DATA_WIDTH(DW),
    .NUM_RES(NR),
    .SEL_W(4),
    .TIMEOUT(8)
  ) dut (
    .UserCLK(clk),
    .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_opa(cpu_opa),
    .cpu_opb(cpu_opb),
    .cpu_res_sel(cpu_res_sel),
    .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_data(cpu_rsp_data),
    .cpu_rsp_err(cpu_rsp_err),
    .fab_opa(fab_opa),
    .fab_opb(fab_opb),
    .fab_start(fab_start),
    .fab_res(fab_res),
    .fab_done(fab_done),
    .cfg_fixed_lat(cfg_fixed_lat),
    .cfg_latency(cfg_latency),
    .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] s);
    int w;
    w = 0;
    while (!cpu_req_ready && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (cpu_req_ready !== 1'b1)
      $display("FAIL send_ready: got %b want 1", cpu_req_ready);
    else
      pass_cnt++;
    cpu_opa = a;
    cpu_opb = b;
    cpu_res_sel = s;
    cpu_req_valid = 1'b1;
    tick();
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n, output int starts);
    n = 0;
    starts = int'(fab_start);
    while (!cpu_rsp_valid && n < 50) begin
      tick();
      n++;
      starts += int'(fab_start);
    end
  endtask

  task automatic handshake();
    cpu_rsp_ready = 1'b1;
    tick();
    cpu_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (cpu_req_ready !== 1'b0 || cpu_rsp_valid !== 1'b0 ||
        fab_start !== 1'b0)
      $display("FAIL rst_ctrl: rdy=%b vld=%b start=%b want 0",
               cpu_req_ready, cpu_rsp_valid, fab_start);
    else pass_cnt++;
    total++;
    if (cpu_rsp_data !== 32'h0 || cpu_rsp_err !== 1'b0 ||
        fab_opa !== 32'h0 || fab_opb !== 32'h0 || perf_cycles !== 32'h0)
      $display("FAIL rst_data: data=%h err=%b opa=%h opb=%h perf=%h want 0",
               cpu_rsp_data, cpu_rsp_err, fab_opa, fab_opb, perf_cycles);
    else pass_cnt++;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (cpu_req_ready !== 1'b0)
      $display("FAIL rst_ready_early: got %b want 0", cpu_req_ready);
    else pass_cnt++;
    tick();
    total++;
    if (cpu_req_ready !== 1'b1)
      $display("FAIL rst_ready_rise: got %b want 1", cpu_req_ready);
    else pass_cnt++;
  endtask

  task automatic test_fixed_latency();
    int n, st;
    cfg_fixed_lat = 1'b1;
    cfg_latency = 4'd3;
    send(32'h0000_1234, 32'h0000_5678, 4'd1);
    total++;
    if (fab_opa !== 32'h0000_1234 || fab_opb !== 32'h0000_5678)
      $display("FAIL fix_ops: opa=%h opb=%h want 00001234 00005678",
               fab_opa, fab_opb);
    else pass_cnt++;
    wait_rsp(n, st);
    total++;
    if (n !== 5)
      $display("FAIL fix_latency: got %0d want 5", n);
    else pass_cnt++;
    total++;
    if (st !== 1)
      $display("FAIL fix_starts: got %0d want 1", st);
    else pass_cnt++;
    total++;
    if (cpu_rsp_data !== CH1 || cpu_rsp_err !== 1'b0)
      $display("FAIL fix_data: data=%h err=%b want %h 0",
               cpu_rsp_data, cpu_rsp_err, CH1);
    else pass_cnt++;
    handshake();
    total++;
    if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1)
      $display("FAIL fix_release: vld=%b rdy=%b want 0 1",
               cpu_rsp_valid, cpu_req_ready);
    else pass_cnt++;
  endtask

  task automatic test_done_mode();
    int n, st;
    logic quiet;
    cfg_fixed_lat = 1'b0;
    send(32'h0000_00AA, 32'h0000_00BB, 4'd0);
    fab_done = 1'b1;
    tick();
    fab_done = 1'b0;
    wait_rsp(n, st);
    n = n + 1;
    total++;
    if (n !== 2)
      $display("FAIL done_latency: got %0d want 2", n);
    else pass_cnt++;
    total++;
    if (cpu_rsp_data !== CH0 || cpu_rsp_err !== 1'b0)
      $display("FAIL done_data: data=%h err=%b want %h 0",
               cpu_rsp_data, cpu_rsp_err, CH0);
    else pass_cnt++;
    handshake();
    fab_done = 1'b1;
    tick();
    fab_done = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      if (cpu_rsp_valid !== 1'b0 || fab_start !== 1'b0 ||
          cpu_req_ready !== 1'b1)
        quiet = 1'b0;
      tick();
    end
    total++;
    if (quiet !== 1'b1)
      $display("FAIL done_idle_ignored: got %b want 1", quiet);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n, st;
    logic [31:0] exp_perf;
`ifdef CIX_PERF_CNT_EN
    exp_perf = 32'd8;
`else
    exp_perf = 32'd0;
`endif
    do_reset();
    cfg_fixed_lat = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 4'd2);
    wait_rsp(n, st);
    total++;
    if (n !== 9)
      $display("FAIL tmo_latency: got %0d want 9", n);
    else pass_cnt++;
    total++;
    if (cpu_rsp_data !== 32'h0 || cpu_rsp_err !== 1'b1)
      $display("FAIL tmo_data: data=%h err=%b want 0 1",
               cpu_rsp_data, cpu_rsp_err);
    else pass_cnt++;
    total++;
    if (perf_cycles !== exp_perf)
      $display("FAIL tmo_perf: got %0d want %0d", perf_cycles, exp_perf);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_bad_select();
    int n, st;
    cfg_fixed_lat = 1'b0;
    send(32'h0000_0003, 32'h0000_0004, 4'd3);
    wait_rsp(n, st);
    total++;
    if (n !== 1)
      $display("FAIL badsel_latency: got %0d want 1", n);
    else pass_cnt++;
    total++;
    if (st !== 0)
      $display("FAIL badsel_starts: got %0d want 0", st);
    else pass_cnt++;
    total++;
    if (cpu_rsp_data !== 32'h0 || cpu_rsp_err !== 1'b1)
      $display("FAIL badsel_data: data=%h err=%b want 0 1",
               cpu_rsp_data, cpu_rsp_err);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_back_to_back();
    int n, st;
    logic stable;
    cfg_fixed_lat = 1'b1;
    cfg_latency = 4'd0;
    send(32'hAAAA_0001, 32'hBBBB_0001, 4'd2);
    wait_rsp(n, st);
    total++;
    if (n !== 2 || cpu_rsp_data !== CH2 || cpu_rsp_err !== 1'b0)
      $display("FAIL b2b_first: n=%0d data=%h err=%b want 2 %h 0",
               n, cpu_rsp_data, cpu_rsp_err, CH2);
    else pass_cnt++;
    cpu_opa = 32'h0000_5555;
    cpu_opb = 32'h0000_6666;
    cpu_res_sel = 4'd0;
    cpu_req_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (cpu_rsp_valid !== 1'b1 || cpu_rsp_data !== CH2 ||
          cpu_rsp_err !== 1'b0 || cpu_req_ready !== 1'b0 ||
          fab_start !== 1'b0)
        stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1)
      $display("FAIL b2b_hold_stable: got %b want 1", stable);
    else pass_cnt++;
    cpu_rsp_ready = 1'b1;
    tick();
    cpu_rsp_ready = 1'b0;
    total++;
    if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1 ||
        fab_start !== 1'b0)
      $display("FAIL b2b_hs_edge: vld=%b rdy=%b start=%b want 0 1 0",
               cpu_rsp_valid, cpu_req_ready, fab_start);
    else pass_cnt++;
    tick();
    cpu_req_valid = 1'b0;
    total++;
    if (fab_start !== 1'b1 || fab_opa !== 32'h0000_5555)
      $display("FAIL b2b_accept: start=%b opa=%h want 1 00005555",
               fab_start, fab_opa);
    else pass_cnt++;
    wait_rsp(n, st);
    total++;
    if (n !== 2 || cpu_rsp_data !== CH0)
      $display("FAIL b2b_second: n=%0d data=%h want 2 %h",
               n, cpu_rsp_data, CH0);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int n, st;
    logic silent;
    cfg_fixed_lat = 1'b0;
    send(32'h0000_7777, 32'h0000_8888, 4'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (cpu_req_ready !== 1'b0 || cpu_rsp_valid !== 1'b0 ||
        cpu_rsp_data !== 32'h0 || cpu_rsp_err !== 1'b0 ||
        fab_opa !== 32'h0 || fab_opb !== 32'h0 || fab_start !== 1'b0 ||
        perf_cycles !== 32'h0)
      $display("FAIL midrst_outputs: rdy=%b vld=%b data=%h opa=%h perf=%h want 0",
               cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, fab_opa,
               perf_cycles);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    silent = 1'b1;
    repeat (15) begin
      tick();
      if (cpu_rsp_valid !== 1'b0) silent = 1'b0;
    end
    total++;
    if (silent !== 1'b1 || cpu_req_ready !== 1'b1)
      $display("FAIL midrst_no_rsp: silent=%b rdy=%b want 1 1",
               silent, cpu_req_ready);
    else pass_cnt++;
    cfg_fixed_lat = 1'b1;
    cfg_latency = 4'd1;
    send(32'h0000_9999, 32'h0000_AAAA, 4'd1);
    wait_rsp(n, st);
    total++;
    if (n !== 3 || cpu_rsp_data !== CH1 || cpu_rsp_err !== 1'b0)
      $display("FAIL midrst_next: n=%0d data=%h err=%b want 3 %h 0",
               n, cpu_rsp_data, cpu_rsp_err, CH1);
    else pass_cnt++;
    handshake();
  endtask

  initial begin
    cpu_req_valid = 1'b0;
    cpu_opa = '0;
    cpu_opb = '0;
    cpu_res_sel = '0;
    cpu_rsp_ready = 1'b0;
    fab_res = {CH2, CH1, CH0};
    fab_done = 1'b0;
    cfg_fixed_lat = 1'b0;
    cfg_latency = '0;
    test_reset();
    test_fixed_latency();
    test_done_mode();
    test_timeout();
    test_bad_select();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
